// File: rtl/ixu_pkg.sv
// Shared types and constants for the IXU writeback/forwarding path.
// XLEN and AW live here so the pipeline entry type and the block ports agree.
package ixu_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic            v;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ixu_fwd_match.sv
// Forward-source selection for one operand: P1 (youngest) beats P2, x0 never forwards.
module ixu_fwd_match
    import ixu_pkg::*;
(
    input  logic [AW-1:0]   rs,
    input  wb_entry_t       p1,
    input  wb_entry_t       p2,
    output logic            hit,
    output logic [XLEN-1:0] data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (rs != REG_ZERO) begin
            if (p1.v && (p1.rd == rs)) begin
                hit  = 1'b1;
                data = p1.data;
            end else if (p2.v && (p2.rd == rs)) begin
                hit  = 1'b1;
                data = p2.data;
            end
        end
    end

endmodule

// File: rtl/ixu_writeback_fwd.sv
// Two-stage writeback pipe (P1 -> P2) committing to the register file via valid/ack,
// and supplying rs1/rs2 forwarding to execute. Datapath widths come from ixu_pkg.
module ixu_writeback_fwd
    import ixu_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_nop,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic [AW-1:0]   ex_rs1,
    input  logic [AW-1:0]   ex_rs2,
    output logic            ex_ready,
    output logic            is_rs1_fwd,
    output logic            is_rs2_fwd,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic [XLEN-1:0] rs2_fwd_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_wack,
    output logic [CW-1:0]   commit_count
);

    wb_entry_t       p1_q, p1_d;
    wb_entry_t       p2_q, p2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cap;
    logic            p2_free;
    logic            commit;

    assign cap     = ex_valid & ~ex_is_nop & (ex_rd != REG_ZERO);
    assign p2_free = ~p2_q.v | rf_wack;
    assign commit  = p2_q.v & rf_wack;

    // Non-capturing instructions still enter P1, as an invalid bubble.
    always_comb begin
        p1_d     = p1_q;
        p2_d     = p2_q;
        cnt_d    = cnt_q;
        ex_ready = ~p1_q.v | p2_free;
        if (p2_free) begin
            p2_d = p1_q;
        end
        if (ex_ready) begin
            p1_d = '{v: cap, rd: ex_rd, data: ex_result};
        end
        if (commit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q  <= '0;
            p2_q  <= '0;
            cnt_q <= '0;
        end else begin
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            cnt_q <= cnt_d;
        end
    end

    assign rf_we        = p2_q.v;
    assign rf_waddr     = p2_q.rd;
    assign rf_wdata     = p2_q.data;
    assign commit_count = cnt_q;

    ixu_fwd_match u_fwd_rs1 (
        .rs   (ex_rs1),
        .p1   (p1_q),
        .p2   (p2_q),
        .hit  (is_rs1_fwd),
        .data (rs1_fwd_data)
    );

    ixu_fwd_match u_fwd_rs2 (
        .rs   (ex_rs2),
        .p1   (p1_q),
        .p2   (p2_q),
        .hit  (is_rs2_fwd),
        .data (rs2_fwd_data)
    );

endmodule

// File: tb/tb_ixu_writeback_fwd.sv
// Bench for ixu_writeback_fwd: directed forwarding/stall checks plus a scoreboard of
// expected register-file writes, with a 4-bit commit counter to exercise wrap.
module tb_ixu_writeback_fwd;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_is_nop;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_ready;
    logic        is_rs1_fwd;
    logic        is_rs2_fwd;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wack;
    logic [3:0]  commit_count;

    ixu_writeback_fwd #(.CW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_is_nop    (ex_is_nop),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_ready     (ex_ready),
        .is_rs1_fwd   (is_rs1_fwd),
        .is_rs2_fwd   (is_rs2_fwd),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_wack      (rf_wack),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [3:0]  model_cnt;
    logic        prev_pend;
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;

    // Scoreboard: accepted capturing instructions in, completed writes out.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            sb.delete();
            model_cnt = '0;
            prev_pend = 1'b0;
        end else begin
            chk("commit_count", 32'(commit_count), 32'(model_cnt));
            if (prev_pend) begin
                chk("hold_we", 32'(rf_we), 32'd1);
                chk("hold_addr", 32'(rf_waddr), 32'(prev_addr));
                chk("hold_data", rf_wdata, prev_data);
            end
            if (rf_we && rf_wack) begin
                if (sb.size() == 0) begin
                    chk("write_with_empty_sb", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(rf_waddr), 32'(e.rd));
                    chk("wr_data", rf_wdata, e.data);
                end
                model_cnt = model_cnt + 4'd1;
            end
            prev_pend = rf_we && !rf_wack;
            prev_addr = rf_waddr;
            prev_data = rf_wdata;
            if (ex_valid && !ex_is_nop && ex_rd != 5'd0 && ex_ready)
                sb.push_back('{rd: ex_rd, data: ex_result});
        end
    end

    task automatic set_ex(input logic v, input logic nop, input logic [4:0] rd,
                          input logic [31:0] res, input logic [4:0] rs1, input logic [4:0] rs2);
        ex_valid  = v;
        ex_is_nop = nop;
        ex_rd     = rd;
        ex_result = res;
        ex_rs1    = rs1;
        ex_rs2    = rs2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_ex(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rf_wack = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_count", 32'(commit_count), 32'd0);
        chk("rst_fwd1", 32'(is_rs1_fwd), 32'd0);
        chk("rst_fwd2_data", rs2_fwd_data, 32'd0);
        rst_n = 1'b1;

        // Reset asserted while P2 holds an un-acked write.
        set_ex(1, 0, 3, 32'h33, 0, 0);
        tick();
        set_ex(0, 0, 0, 0, 3, 3);
        tick();
        chk("pend_we", 32'(rf_we), 32'd1);
        chk("pend_addr", 32'(rf_waddr), 32'd3);
        chk("pend_fwd1", 32'(is_rs1_fwd), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(rf_we), 32'd0);
        chk("midrst_count", 32'(commit_count), 32'd0);
        chk("midrst_fwd1", 32'(is_rs1_fwd), 32'd0);
        chk("midrst_fwd2", 32'(is_rs2_fwd), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rf_wack = 1'b1;
        set_ex(0, 0, 0, 0, 0, 0);
        tick();

        // Back-to-back forward from P1, write exactly two cycles later.
        set_ex(1, 0, 5, 32'h10, 0, 0);
        tick();
        set_ex(1, 0, 0, 32'h0, 5, 0);
        @(negedge clk);
        chk("b2b_fwd1", 32'(is_rs1_fwd), 32'd1);
        chk("b2b_fwd1_data", rs1_fwd_data, 32'h10);
        chk("b2b_we_early", 32'(rf_we), 32'd0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_we", 32'(rf_we), 32'd1);
        chk("b2b_waddr", 32'(rf_waddr), 32'd5);
        chk("b2b_wdata", rf_wdata, 32'h10);
        tick();
        @(negedge clk);
        chk("b2b_count", 32'(commit_count), 32'd1);
        tick();

        // Youngest producer wins.
        set_ex(1, 0, 7, 32'hAAAA, 0, 0);
        tick();
        set_ex(1, 0, 7, 32'hBBBB, 0, 0);
        tick();
        set_ex(0, 0, 0, 0, 7, 7);
        @(negedge clk);
        chk("prio_fwd2", 32'(is_rs2_fwd), 32'd1);
        chk("prio_fwd2_data", rs2_fwd_data, 32'hBBBB);
        chk("prio_fwd1_data", rs1_fwd_data, 32'hBBBB);
        tick();
        @(negedge clk);
        chk("p2_fwd2", 32'(is_rs2_fwd), 32'd1);
        chk("p2_fwd2_data", rs2_fwd_data, 32'hBBBB);
        tick();
        idle(3);

        // x0 destination and NOP are never written or forwarded.
        set_ex(1, 0, 0, 32'h55, 0, 0);
        @(negedge clk);
        chk("x0_we", 32'(rf_we), 32'd0);
        tick();
        set_ex(1, 1, 4, 32'h44, 0, 0);
        @(negedge clk);
        chk("x0_fwd1", 32'(is_rs1_fwd), 32'd0);
        chk("x0_fwd1_data", rs1_fwd_data, 32'd0);
        tick();
        set_ex(0, 0, 0, 0, 4, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nop_we", 32'(rf_we), 32'd0);
            chk("nop_fwd1", 32'(is_rs1_fwd), 32'd0);
            tick();
        end

        // Backpressure: three issues with no ack.
        rf_wack = 1'b0;
        set_ex(1, 0, 10, 32'h100, 0, 0);
        @(negedge clk);
        chk("bp_ready0", 32'(ex_ready), 32'd1);
        tick();
        set_ex(1, 0, 11, 32'h101, 0, 0);
        @(negedge clk);
        chk("bp_ready1", 32'(ex_ready), 32'd1);
        tick();
        set_ex(1, 0, 12, 32'h102, 11, 10);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_stall", 32'(ex_ready), 32'd0);
            chk("bp_waddr", 32'(rf_waddr), 32'd10);
            chk("bp_wdata", rf_wdata, 32'h100);
            chk("bp_fwd1_data", rs1_fwd_data, 32'h101);
            chk("bp_fwd2_data", rs2_fwd_data, 32'h100);
            tick();
        end
        rf_wack = 1'b1;
        @(negedge clk);
        chk("bp_ready_ack", 32'(ex_ready), 32'd1);
        tick();
        idle(4);
        @(negedge clk);
        chk("bp_count", 32'(commit_count), 32'd6);
        tick();

        // Eleven more commits: 17 total wraps the 4-bit counter to 1.
        for (int i = 0; i < 11; i++) begin
            set_ex(1, 0, 5'(i % 31 + 1), $urandom, 5'(i % 31 + 1), 0);
            tick();
        end
        idle(4);
        @(negedge clk);
        chk("wrap_count", 32'(commit_count), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ixu_writeback_fwd.md
Name: ixu_writeback_fwd

Overview:
- Producer side of the IXU execute operand-forwarding interface.
- Captures the integer ALU result and destination register each cycle into a two-stage writeback pipeline (P1, P2).
- Commits P2 to the register-file write port through a valid/ack handshake.
- Drives the rs1/rs2 forward-select and forward-data signals back to the execute stage for the instruction currently in execute.

Parameters:
- XLEN, 32, datapath width; must equal the execute-stage operand width.
- AW, 5, register address width; register 0 is hardwired zero.
- CW, 32, width of the commit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage holds a live instruction this cycle
- ex_is_nop  in  1  instruction is a NOP; never written back or forwarded
- ex_rd  in  AW  destination register of the executing instruction
- ex_result  in  XLEN  execute-stage ALU output
- ex_rs1  in  AW  source register 1 of the executing instruction
- ex_rs2  in  AW  source register 2 of the executing instruction
- ex_ready  out  1  writeback can accept the execute result this cycle
- is_rs1_fwd  out  1  execute should use rs1_fwd_data
- is_rs2_fwd  out  1  execute should use rs2_fwd_data
- rs1_fwd_data  out  XLEN  forwarded rs1 value
- rs2_fwd_data  out  XLEN  forwarded rs2 value
- rf_we  out  1  register-file write request (valid)
- rf_waddr  out  AW  write address
- rf_wdata  out  XLEN  write data
- rf_wack  in  1  register file accepted the write this cycle
- commit_count  out  CW  number of retired register writes

Behaviour:
- Reset (async, rst_n=0):
  - P1 and P2 valid bits are 0, so rf_we=0 and is_rs*_fwd=0.
  - rf_waddr, rf_wdata, all fwd data = 0; commit_count = 0.
  - ex_ready = 1 after reset.
  - A reset asserted mid-handshake drops the pending write with no commit.
- Capture qualifier: cap = ex_valid & ~ex_is_nop & (ex_rd != 0). Non-capturing instructions still advance the pipe, as a bubble.
- Advance rules, evaluated in the same cycle:
  - p2_free = ~P2.v | rf_wack
  - p1_move = p2_free
  - ex_ready = ~P1.v | p2_free
- On a rising edge:
  - If p1_move: P2 <= P1.
  - If ex_ready: P1 <= {cap, ex_rd, ex_result}.
  - Otherwise P1 holds.
- Write port: rf_we = P2.v; rf_waddr and rf_wdata = P2 fields.
  - These must stay stable while rf_we=1 and rf_wack=0.
  - A write is done on a cycle with rf_we & rf_wack.
  - rf_wack while rf_we=0 is ignored.
- Latency: a result is written ≥2 cycles after its execute cycle, exactly 2 with constant rf_wack=1. Throughput is 1 per cycle.
- Forwarding (combinational from P1/P2, per source rsN):
  - If rsN == 0: no forward, is_rsN_fwd=0, data=0.
  - Else if P1.v & P1.rd==rsN: forward P1.data. P1 is the youngest and wins.
  - Else if P2.v & P2.rd==rsN: forward P2.data. This covers the un-acked and same-cycle-write cases.
  - Else is_rsN_fwd=0, data=0.
  - rs1 and rs2 are independent; both may hit the same stage.
- commit_count increments by 1 on each completed write and wraps modulo 2^CW.
- Stall: with P1.v=1, P2.v=1 and rf_wack=0, ex_ready=0 and neither stage changes. The upstream stage must hold ex_* stable while ex_ready=0. Forwarding stays valid during the stall.
- Simultaneous events: rf_wack together with a full pipe gives P2<=P1 and P1<=new in the same edge, with no bubble.

Decomposition:
- Shared package ixu_pkg holds:
  - XLEN and AW constants
  - typedef wb_entry_t {logic v; logic [AW-1:0] rd; logic [XLEN-1:0] data;}
  - constant REG_ZERO
- One sub-module, ixu_fwd_match, is instantiated twice (rs1, rs2). It takes a source register and the two wb_entry_t and outputs {hit, data}. It is purely combinational priority logic.

Test Plan:
- Reset mid-write: P2 holding rd=3, no ack; assert rst_n=0 -> rf_we=0, commit_count=0, is_rs*_fwd=0 asynchronously.
- Back-to-back, rf_wack=1: ADD rd=5 result 0x10, then next cycle ex_rs1=5 -> is_rs1_fwd=1, rs1_fwd_data=0x10 from P1. Write of r5=0x10 occurs exactly 2 cycles after execute; commit_count=1.
- Priority: r7=0xAAAA then r7=0xBBBB on consecutive cycles, then ex_rs2=7 -> rs2_fwd_data=0xBBBB (P1), not 0xAAAA.
- x0 and NOP filtering: ex_rd=0 result 0x55, then ex_is_nop=1 with ex_rd=4 -> no rf_we ever asserted; ex_rs1=0 -> is_rs1_fwd=0.
- Backpressure: rf_wack=0 for 3 cycles with 3 instructions issued -> ex_ready drops to 0 once P1 and P2 are full; rf_waddr/rf_wdata stable. Raise rf_wack -> writes in order, nothing lost or duplicated, commit_count=3.
- Counter wrap with CW=4: 17 committed writes -> commit_count=1.
